// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: beam position, sync, blanking, line/frame
// strobes and a completed-frame counter. Every output comes straight from a
// flop. The decodes are computed from the next beam position, so they always
// match the hpos/vpos presented in the same cycle.
module vga_timing_gen #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic [7:0] frame_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       display_next;
  logic       line_next;
  logic       frame_start_next;

  // Next beam position and frame count; run=0 holds everything in place.
  always_comb begin
    h_next     = hpos;
    v_next     = vpos;
    frame_next = frame;
    if (run) begin
      if (hpos == H_LAST) begin
        h_next = 10'd0;
        if (vpos == V_LAST) begin
          v_next     = 10'd0;
          frame_next = frame + 8'd1;
        end else begin
          v_next = vpos + 10'd1;
        end
      end else begin
        h_next = hpos + 10'd1;
      end
    end
  end

  // Decode sync, blanking and strobes from the position about to be loaded.
  always_comb begin
    hsync_next       = ((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_next       = ((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    display_next     = (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
    line_next        = (h_next == 10'd0);
    frame_start_next = (h_next == 10'd0) && (v_next == 10'd0);
  end

  // Register counters and decoded outputs together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= 10'd0;
      vpos        <= 10'd0;
      frame       <= 8'd0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      display_on  <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hpos        <= h_next;
      vpos        <= v_next;
      frame       <= frame_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      display_on  <= display_next;
      line_start  <= line_next;
      frame_start <= frame_start_next;
    end
  end

endmodule
